seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Programmable serial pattern detector (Moore output) for single-bit streams.
//  Generalises the fixed 4-bit detector: pattern width is a parameter and the pattern is runtime-loadable.
//  Overlapping/non-overlapping mode is runtime-selectable, the input is valid-qualified, and matches are counted.
//  Sits after any serial bit source; y feeds control logic, match_count feeds status readback.
// PARAMETERS
//  PAT_W        4        pattern length in bits, legal range 2..32
//  CNT_W        8        match counter width, legal range 1..32
//  RST_PATTERN  4'b1011  pattern loaded at reset, PAT_W bits, MSB = first bit received
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  en           in   1      x valid; a bit is accepted only on edges where en=1
//  x            in   1      serial input bit
//  overlap      in   1      1 = overlapping detection, 0 = non-overlapping
//  pat_load     in   1      load pat_in into pattern register
//  pat_in       in   PAT_W  new pattern, MSB = first bit of sequence
//  cnt_clr      in   1      clear match_count
//  y            out  1      registered match flag (Moore)
//  match_count  out  CNT_W  saturating count of matches
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - pat_q=RST_PATTERN, history hist=0, fill=0, y=0, match_count=0.
//    - Reset overrides every other input; a reset mid-sequence discards partial history.
//  - Accept (en=1, pat_load=0):
//    - hist_n = {hist[PAT_W-2:0], x}; fill_n = min(fill+1, PAT_W).
//    - hit = (fill_n == PAT_W) && (hist_n == pat_q).
//  - Non-overlap: on hit, fill resets to 0, so the next match needs PAT_W fresh bits.
//    - Overlap: on hit, fill stays at PAT_W; hist always takes hist_n.
//  - y: registered hit. It is high for exactly the one cycle after the edge that accepted the final bit.
//    - y is 0 on every cycle that does not follow a hit, including en=0 cycles.
//    - Back-to-back hits (e.g. pattern all-ones, overlap=1) give consecutive high cycles.
//  - Latency: y rises 1 cycle after the final pattern bit is sampled.
//  - pat_load=1:
//    - pat_q<=pat_in; hist=0; fill=0; y<=0.
//    - Any en/x on that edge is ignored; loaded pattern applies from the next accepted bit.
//  - overlap is sampled at each hit; a change takes effect at the next hit.
//  - match_count: +1 per hit, saturates at 2^CNT_W-1 (no wrap).
//    - cnt_clr alone -> 0. cnt_clr with a hit on the same edge -> 1.
//  - en=0: hist, fill and count hold; y goes/stays 0.
//  - Unreachable/illegal fill values recover to 0 (default branch).
//  - Elaboration error if PAT_W<2, PAT_W>32, or CNT_W<1.
// TESTING
//  1. Defaults, overlap=1, en=1, x=1,0,1,1,0,1,1 -> y high cycle after bit4 and bit7; match_count=2.
//  2. Same stream, overlap=0 -> single y pulse after bit4; bits 5-7 give no hit; match_count=1.
//  3. Stream 1,0,1,1 with en=0 gaps of 3 cycles (x toggling during gaps) -> one y pulse after 4th accepted bit only.
//  4. Feed 1,1; pat_load pat_in=4'b1111; feed 1,1 -> no hit (history cleared).
//     Then overlap=1, 6 ones -> y high 3 consecutive cycles; count=3.
//  5. CNT_W=2, 5 hits -> match_count=3 (saturated). cnt_clr on a hit edge -> match_count=1.
//  6. Feed 1,0,1, assert rst one cycle, feed 1 -> no hit; y=0, match_count=0, pat_q=1011.

Source files
------------

// File: rtl/seq_detector_prog.sv
// seq_detector_prog
//   Programmable serial pattern detector with a registered (Moore) match flag.
//   The pattern is loadable at runtime, overlapping or non-overlapping detection
//   is selectable, input bits are valid-qualified, and matches are counted into
//   a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           x valid; a bit is shifted in only when en=1
//   x            serial input bit
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pat_load     load pat_in into the pattern register, clears history
//   pat_in       new pattern, MSB = first bit of the sequence
//   cnt_clr      clear match_count (a hit on the same edge leaves it at 1)
//   y            registered match flag, high the cycle after a hit
//   match_count  saturating match counter
module seq_detector_prog #(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             y,
   output logic [CNT_W-1:0] match_count
);

   generate
      if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_param_err
         $error("seq_detector_prog: PAT_W must be 2..32 and CNT_W >= 1");
      end
   endgenerate

   // fill counts valid history bits, 0..PAT_W
   localparam int               FW       = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] hist_q;
   logic [FW-1:0]    fill_q;

   logic [PAT_W-1:0] hist_n;
   logic [FW-1:0]    fill_inc;
   logic             accept;
   logic             hit;

   always_comb begin
      hist_n = {hist_q[PAT_W-2:0], x};
      // saturate at PAT_W; any out-of-range fill recovers to 0
      if (fill_q < FILL_MAX)
         fill_inc = fill_q + FW'(1);
      else if (fill_q == FILL_MAX)
         fill_inc = FILL_MAX;
      else
         fill_inc = '0;
      accept = en && !pat_load;
      hit    = accept && (fill_inc == FILL_MAX) && (hist_n == pat_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q       <= RST_PATTERN;
         hist_q      <= '0;
         fill_q      <= '0;
         y           <= 1'b0;
         match_count <= '0;
      end else begin
         y <= hit;

         if (pat_load) begin
            pat_q  <= pat_in;
            hist_q <= '0;
            fill_q <= '0;
         end else if (en) begin
            hist_q <= hist_n;
            // non-overlap: a hit consumes the window, next match needs PAT_W fresh bits
            fill_q <= (hit && !overlap) ? '0 : fill_inc;
         end

         if (cnt_clr)
            match_count <= hit ? CNT_W'(1) : '0;
         else if (hit && match_count != CNT_MAX)
            match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

   logic       clk;
   logic       rst;
   logic       en;
   logic       x;
   logic       overlap;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       cnt_clr;
   logic       y;
   logic [7:0] cnt;
   logic       y2;
   logic [1:0] cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   seq_detector_prog dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .y(y), .match_count(cnt)
   );

   seq_detector_prog #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .y(y2), .match_count(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic feed(input logic b);
      en = 1'b1;
      x  = b;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y got=%b exp=0", y); end
      n_checks++;
      if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
   endtask

   task automatic test_overlap();
      logic [6:0] bits;
      logic [6:0] exp_y;
      bits  = 7'b1011011;   // MSB first
      exp_y = 7'b0001001;
      do_reset();
      overlap = 1'b1;
      for (int i = 6; i >= 0; i--) begin
         feed(bits[i]);
         n_checks++;
         if (y !== exp_y[i]) begin
            n_fail++; $display("FAIL overlap_y bit%0d got=%b exp=%b", 7 - i, y, exp_y[i]);
         end
      end
      n_checks++;
      if (cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt got=%0d exp=2", cnt); end
      // idle cycle drops y and holds count
      en = 1'b0;
      tick();
      n_checks++;
      if (y !== 1'b0 || cnt !== 8'd2) begin
         n_fail++; $display("FAIL idle_hold y=%b cnt=%0d exp y=0 cnt=2", y, cnt);
      end
   endtask

   task automatic test_non_overlap();
      logic [6:0] bits;
      logic [6:0] exp_y;
      bits  = 7'b1011011;
      exp_y = 7'b0001000;
      do_reset();
      overlap = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         feed(bits[i]);
         n_checks++;
         if (y !== exp_y[i]) begin
            n_fail++; $display("FAIL nonovl_y bit%0d got=%b exp=%b", 7 - i, y, exp_y[i]);
         end
      end
      n_checks++;
      if (cnt !== 8'd1) begin n_fail++; $display("FAIL nonovl_cnt got=%0d exp=1", cnt); end
   endtask

   task automatic test_en_gaps();
      logic [3:0] bits;
      bits = 4'b1011;
      do_reset();
      overlap = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         feed(bits[i]);
         n_checks++;
         if (y !== (i == 0)) begin
            n_fail++; $display("FAIL gap_y_accept bit%0d got=%b exp=%b", 4 - i, y, (i == 0));
         end
         en = 1'b0;
         for (int g = 0; g < 3; g++) begin
            x = ~x;
            tick();
            n_checks++;
            if (y !== 1'b0) begin
               n_fail++; $display("FAIL gap_y_idle bit%0d gap%0d got=%b exp=0", 4 - i, g, y);
            end
         end
      end
      n_checks++;
      if (cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt got=%0d exp=1", cnt); end
   endtask

   task automatic test_pat_load();
      logic [5:0] exp_y;
      exp_y = 6'b000111;
      do_reset();
      overlap = 1'b1;
      feed(1'b1);
      feed(1'b1);
      // en/x on the load edge must be ignored
      en = 1'b1; x = 1'b1; pat_load = 1'b1; pat_in = 4'b1111;
      tick();
      pat_load = 1'b0;
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL load_edge_y got=%b exp=0", y); end
      feed(1'b1);
      feed(1'b1);
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL load_hist_cleared got=%b exp=0", y); end
      pat_load = 1'b1; en = 1'b0;
      tick();
      pat_load = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         feed(1'b1);
         n_checks++;
         if (y !== exp_y[i]) begin
            n_fail++; $display("FAIL ones_y bit%0d got=%b exp=%b", 6 - i, y, exp_y[i]);
         end
      end
      n_checks++;
      if (cnt !== 8'd3) begin n_fail++; $display("FAIL ones_cnt got=%0d exp=3", cnt); end
   endtask

   task automatic test_saturate_clr();
      do_reset();
      overlap = 1'b1;
      pat_load = 1'b1; pat_in = 4'b1111;
      tick();
      pat_load = 1'b0;
      for (int i = 0; i < 8; i++) feed(1'b1);
      n_checks++;
      if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
      n_checks++;
      if (cnt !== 8'd5) begin n_fail++; $display("FAIL sat_cnt8 got=%0d exp=5", cnt); end
      cnt_clr = 1'b1;
      feed(1'b1);
      n_checks++;
      if (cnt2 !== 2'd1 || cnt !== 8'd1 || y !== 1'b1) begin
         n_fail++; $display("FAIL clr_hit cnt2=%0d cnt=%0d y=%b exp 1 1 1", cnt2, cnt, y);
      end
      en = 1'b0;
      tick();
      cnt_clr = 1'b0;
      n_checks++;
      if (cnt2 !== 2'd0 || cnt !== 8'd0) begin
         n_fail++; $display("FAIL clr_alone cnt2=%0d cnt=%0d exp 0 0", cnt2, cnt);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      overlap = 1'b1;
      feed(1'b1);
      feed(1'b0);
      feed(1'b1);
      rst = 1'b1; en = 1'b1; x = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (y !== 1'b0 || cnt !== 8'd0) begin
         n_fail++; $display("FAIL midrst_state y=%b cnt=%0d exp 0 0", y, cnt);
      end
      feed(1'b1);
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL midrst_nohit got=%b exp=0", y); end
      // pattern restored to 1011: completing 1,0,1,1 must hit
      feed(1'b0);
      feed(1'b1);
      feed(1'b1);
      n_checks++;
      if (y !== 1'b1 || cnt !== 8'd1) begin
         n_fail++; $display("FAIL midrst_pat y=%b cnt=%0d exp 1 1", y, cnt);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b1;
      pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_en_gaps();
      test_pat_load();
      test_saturate_clr();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
